if_id_buffer: RTL and testbench
===============================

IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port rst_b  input  1  reset; synchronous, active-low; sampled only on rising clk edges.
REQ-003 SHALL have port in_valid  input  1  fetch presents a valid instruction.
REQ-004 SHALL have port in_ready  output  1  buffer accepts an instruction this cycle.
REQ-005 SHALL have port PC_plus_4  input  32  PC+4 of the fetched instruction.
REQ-006 SHALL have port instruction  input  32  fetched instruction word.
REQ-007 SHALL have port flush  input  1  taken branch; discard all buffered instructions.
REQ-008 SHALL have port out_valid  output  1  head entry valid toward decode.
REQ-009 SHALL have port out_ready  input  1  decode consumes head; 0 on load-use stall.
REQ-010 SHALL have port PC_plus_4_copy  output  32  head entry PC+4.
REQ-011 SHALL have port instruction_copy  output  32  head entry instruction.
REQ-012 SHALL have port halted  output  1  halt instruction has left the buffer; fetch stops.

Function
REQ-013 SHALL hold a 2-entry in-order FIFO (entry0 = head); each entry stores {PC_plus_4, instruction}; 2-bit count in 0..2.
REQ-014 SHALL define push = in_valid & in_ready and pop = out_valid & out_ready, both evaluated at the rising edge.
REQ-015 SHALL drive in_ready = rst_b & (state==RUN) & (count<2) & ~flush; no push when count==2, even with a simultaneous pop.
REQ-016 SHALL drive out_valid = (count!=0) & (state!=HALTED), registered, with no combinational path from in_valid.
REQ-017 SHALL drive PC_plus_4_copy/instruction_copy from entry0; entry0 SHALL be 32'h0 in both fields whenever count==0 (bubble = NOP).
REQ-018 SHALL, on pop only, shift entry1 to entry0 and decrement count; on push only, write slot[count] and increment count.
REQ-019 SHALL, on simultaneous push and pop with count==1, load the input into entry0 and keep count at 1.
REQ-020 SHALL treat the same cycle as pop+push into empty slot when count==2: push is blocked (REQ-015), pop alone proceeds.
REQ-021 SHALL, on flush, set count to 0 and zero both entries next cycle; same-cycle push and pop are discarded (pop still counts as consumed by decode).
REQ-022 SHALL implement states RUN, DRAIN, HALTED.
REQ-023 RUN->DRAIN SHALL occur when the pushed instruction equals 32'h0000000C (syscall = halt).
REQ-024 DRAIN->HALTED SHALL occur when the entry being popped holds 32'h0000000C.
REQ-025 DRAIN->RUN SHALL occur on flush (halt was on the wrong path); flush has priority over REQ-024 in the same cycle.
REQ-026 HALTED SHALL be terminal until reset; flush in HALTED clears entries but leaves state unchanged.
REQ-027 SHALL drive halted = (state==HALTED), registered.

Reset
REQ-028 SHALL, while rst_b==0 at a rising edge, set count=0, entries=0, state=RUN, out_valid=0, halted=0, PC_plus_4_copy=0, instruction_copy=0.
REQ-029 SHALL reset mid-operation (any state, any count) to the REQ-028 values on the next edge; in_ready=0 while rst_b==0.

Verification
REQ-030 Stream: in_valid=1 with instructions A(PC+4=0x4), B(0x8), out_ready=1 -> A on outputs cycle after push, B next; count never exceeds 1.
REQ-031 Stall: push A,B with out_ready=0 -> count=2, in_ready=0, outputs hold A; release out_ready -> A, then B, then out_valid=0 with outputs 0.
REQ-032 Flush: count=2, flush=1 with in_valid=1 -> next cycle out_valid=0, outputs 0, input discarded; in_ready=1 the following cycle.
REQ-033 Halt: push 32'h0000000C after A -> in_ready=0 immediately after; pop A, pop halt -> halted=1, out_valid=0, remains through further flush.
REQ-034 Wrong-path halt: push 32'h0000000C, then flush before it pops -> state RUN, in_ready=1, halted=0.
REQ-035 Reset mid-op: count=2 in DRAIN, rst_b=0 one edge -> all outputs 0, in_ready=1 after rst_b returns to 1.

Source files
------------

// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: 2-entry in-order FIFO between fetch and decode.
// Handles decode stalls, branch flushes and a syscall-based halt sequence
// (RUN -> DRAIN -> HALTED). Every output toward decode comes from a flop.
module if_id_buffer (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] PC_plus_4,
    input  logic [31:0] instruction,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] PC_plus_4_copy,
    output logic [31:0] instruction_copy,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [31:0] HALT_INSN = 32'h0000000C;

    state_t      state_q, state_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] e0_pc_q, e0_pc_d;
    logic [31:0] e0_ins_q, e0_ins_d;
    logic [31:0] e1_pc_q, e1_pc_d;
    logic [31:0] e1_ins_q, e1_ins_d;
    logic        out_valid_q, out_valid_d;
    logic        halted_q, halted_d;
    logic        push_s;
    logic        pop_s;

    // Fetch may only push while running, with a free slot, not flushing and out of reset.
    assign in_ready = rst_b & (state_q == ST_RUN) & (count_q < 2'd2) & ~flush;
    assign push_s   = in_valid & in_ready;
    assign pop_s    = out_valid_q & out_ready;

    assign out_valid        = out_valid_q;
    assign halted           = halted_q;
    assign PC_plus_4_copy   = e0_pc_q;
    assign instruction_copy = e0_ins_q;

    // FIFO storage update; vacated slots are zeroed so an empty head reads as a NOP.
    always_comb begin
        count_d  = count_q;
        e0_pc_d  = e0_pc_q;
        e0_ins_d = e0_ins_q;
        e1_pc_d  = e1_pc_q;
        e1_ins_d = e1_ins_q;
        if (flush) begin
            count_d  = 2'd0;
            e0_pc_d  = 32'h0;
            e0_ins_d = 32'h0;
            e1_pc_d  = 32'h0;
            e1_ins_d = 32'h0;
        end else begin
            case ({push_s, pop_s})
                2'b11: begin
                    if (count_q == 2'd1) begin
                        // Head leaves while the new word takes its place.
                        e0_pc_d  = PC_plus_4;
                        e0_ins_d = instruction;
                        e1_pc_d  = 32'h0;
                        e1_ins_d = 32'h0;
                    end else begin
                        // Not reachable (push blocked at count 2); treat as pop.
                        e0_pc_d  = e1_pc_q;
                        e0_ins_d = e1_ins_q;
                        e1_pc_d  = 32'h0;
                        e1_ins_d = 32'h0;
                        count_d  = count_q - 2'd1;
                    end
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        e0_pc_d  = PC_plus_4;
                        e0_ins_d = instruction;
                    end else begin
                        e1_pc_d  = PC_plus_4;
                        e1_ins_d = instruction;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    e0_pc_d  = e1_pc_q;
                    e0_ins_d = e1_ins_q;
                    e1_pc_d  = 32'h0;
                    e1_ins_d = 32'h0;
                    count_d  = count_q - 2'd1;
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    // Halt sequencing: a pushed syscall drains the buffer, halting once it is consumed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (!flush && push_s && (instruction == HALT_INSN)) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (flush) begin
                    state_d = ST_RUN;      // halt was on the wrong path
                end else if (pop_s && (e0_ins_q == HALT_INSN)) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        out_valid_d = (count_d != 2'd0) & (state_d != ST_HALTED);
        halted_d    = (state_d == ST_HALTED);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q     <= ST_RUN;
            count_q     <= 2'd0;
            e0_pc_q     <= 32'h0;
            e0_ins_q    <= 32'h0;
            e1_pc_q     <= 32'h0;
            e1_ins_q    <= 32'h0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            e0_pc_q     <= e0_pc_d;
            e0_ins_q    <= e0_ins_d;
            e1_pc_q     <= e1_pc_d;
            e1_ins_q    <= e1_ins_d;
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer: stream, stall, flush, halt and reset cases.
module tb_if_id_buffer;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] PC_plus_4;
    logic [31:0] instruction;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] PC_plus_4_copy;
    logic [31:0] instruction_copy;
    logic        halted;

    int passed = 0;
    int total  = 0;

    localparam logic [31:0] INS_A = 32'h11111111;
    localparam logic [31:0] INS_B = 32'h22222222;
    localparam logic [31:0] INS_D = 32'h44444444;
    localparam logic [31:0] HALT  = 32'h0000000C;

    if_id_buffer dut (
        .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready),
        .PC_plus_4(PC_plus_4), .instruction(instruction), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .PC_plus_4_copy(PC_plus_4_copy), .instruction_copy(instruction_copy),
        .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        in_valid    = v;
        PC_plus_4   = pc;
        instruction = ins;
    endtask

    task automatic test_reset();
        rst_b = 1'b0; flush = 1'b0; out_ready = 1'b0; drive(1'b0, 32'h0, 32'h0);
        step(); step();
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0b exp=0", out_valid); else passed++;
        total++; if (halted !== 1'b0) $display("FAIL reset_halted got=%0b exp=0", halted); else passed++;
        total++; if (PC_plus_4_copy !== 32'h0 || instruction_copy !== 32'h0)
            $display("FAIL reset_copies got=%h/%h exp=0/0", PC_plus_4_copy, instruction_copy); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready_low got=%0b exp=0", in_ready); else passed++;
        rst_b = 1'b1; #1;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready_high got=%0b exp=1", in_ready); else passed++;
    endtask

    task automatic test_stream();
        out_ready = 1'b1; drive(1'b1, 32'h4, INS_A);
        step();
        total++; if (out_valid !== 1'b1 || PC_plus_4_copy !== 32'h4 || instruction_copy !== INS_A)
            $display("FAIL stream_a got=%0b %h %h exp=1 4 %h", out_valid, PC_plus_4_copy, instruction_copy, INS_A); else passed++;
        drive(1'b1, 32'h8, INS_B); #1;
        total++; if (in_ready !== 1'b1) $display("FAIL stream_in_ready got=%0b exp=1", in_ready); else passed++;
        step();
        total++; if (out_valid !== 1'b1 || PC_plus_4_copy !== 32'h8 || instruction_copy !== INS_B)
            $display("FAIL stream_b got=%0b %h %h exp=1 8 %h", out_valid, PC_plus_4_copy, instruction_copy, INS_B); else passed++;
        drive(1'b0, 32'h0, 32'h0);
        step();
        total++; if (out_valid !== 1'b0 || PC_plus_4_copy !== 32'h0 || instruction_copy !== 32'h0)
            $display("FAIL stream_empty got=%0b %h %h exp=0 0 0", out_valid, PC_plus_4_copy, instruction_copy); else passed++;
    endtask

    task automatic test_stall();
        out_ready = 1'b0; drive(1'b1, 32'h4, INS_A);
        step();
        drive(1'b1, 32'h8, INS_B);
        step();
        drive(1'b1, 32'h10, INS_D); out_ready = 1'b1; #1;
        total++; if (in_ready !== 1'b0) $display("FAIL stall_full_in_ready got=%0b exp=0", in_ready); else passed++;
        total++; if (out_valid !== 1'b1 || PC_plus_4_copy !== 32'h4 || instruction_copy !== INS_A)
            $display("FAIL stall_hold_a got=%0b %h %h exp=1 4 %h", out_valid, PC_plus_4_copy, instruction_copy, INS_A); else passed++;
        step();
        drive(1'b0, 32'h0, 32'h0);
        total++; if (out_valid !== 1'b1 || PC_plus_4_copy !== 32'h8 || instruction_copy !== INS_B)
            $display("FAIL stall_release_b got=%0b %h %h exp=1 8 %h", out_valid, PC_plus_4_copy, instruction_copy, INS_B); else passed++;
        step();
        total++; if (out_valid !== 1'b0 || PC_plus_4_copy !== 32'h0 || instruction_copy !== 32'h0)
            $display("FAIL stall_drained got=%0b %h %h exp=0 0 0", out_valid, PC_plus_4_copy, instruction_copy); else passed++;
    endtask

    task automatic test_flush();
        out_ready = 1'b0; drive(1'b1, 32'h4, INS_A);
        step();
        drive(1'b1, 32'h8, INS_B);
        step();
        drive(1'b1, 32'h10, INS_D); flush = 1'b1; #1;
        total++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready_low got=%0b exp=0", in_ready); else passed++;
        step();
        flush = 1'b0; drive(1'b0, 32'h0, 32'h0); #1;
        total++; if (out_valid !== 1'b0 || PC_plus_4_copy !== 32'h0 || instruction_copy !== 32'h0)
            $display("FAIL flush_cleared got=%0b %h %h exp=0 0 0", out_valid, PC_plus_4_copy, instruction_copy); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready_high got=%0b exp=1", in_ready); else passed++;
    endtask

    task automatic test_wrong_path_halt();
        out_ready = 1'b0; drive(1'b1, 32'h10, HALT);
        step();
        drive(1'b0, 32'h0, 32'h0); #1;
        total++; if (in_ready !== 1'b0) $display("FAIL wp_drain_in_ready got=%0b exp=0", in_ready); else passed++;
        flush = 1'b1;
        step();
        flush = 1'b0; #1;
        total++; if (in_ready !== 1'b1 || halted !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL wp_back_to_run got=%0b %0b %0b exp=1 0 0", in_ready, halted, out_valid); else passed++;
        out_ready = 1'b1; drive(1'b1, 32'h4, INS_A);
        step();
        drive(1'b0, 32'h0, 32'h0);
        total++; if (out_valid !== 1'b1 || instruction_copy !== INS_A)
            $display("FAIL wp_accepts got=%0b %h exp=1 %h", out_valid, instruction_copy, INS_A); else passed++;
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; drive(1'b1, 32'h4, INS_A);
        step();
        drive(1'b1, 32'h8, HALT);
        step();
        drive(1'b0, 32'h0, 32'h0); #1;
        total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) $display("FAIL mid_setup got=%0b %0b exp=0 1", in_ready, out_valid); else passed++;
        rst_b = 1'b0;
        step();
        total++; if (out_valid !== 1'b0 || halted !== 1'b0 || PC_plus_4_copy !== 32'h0 || instruction_copy !== 32'h0 || in_ready !== 1'b0)
            $display("FAIL mid_reset got=%0b %0b %h %h %0b exp=0 0 0 0 0", out_valid, halted, PC_plus_4_copy, instruction_copy, in_ready); else passed++;
        rst_b = 1'b1; #1;
        total++; if (in_ready !== 1'b1) $display("FAIL mid_in_ready got=%0b exp=1", in_ready); else passed++;
    endtask

    task automatic test_halt();
        out_ready = 1'b0; drive(1'b1, 32'h4, INS_A);
        step();
        drive(1'b1, 32'h8, HALT);
        step();
        drive(1'b0, 32'h0, 32'h0); #1;
        total++; if (in_ready !== 1'b0) $display("FAIL halt_in_ready got=%0b exp=0", in_ready); else passed++;
        out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b1 || instruction_copy !== HALT || PC_plus_4_copy !== 32'h8 || halted !== 1'b0)
            $display("FAIL halt_head got=%0b %h %h %0b exp=1 c 8 0", out_valid, instruction_copy, PC_plus_4_copy, halted); else passed++;
        step();
        total++; if (halted !== 1'b1 || out_valid !== 1'b0 || instruction_copy !== 32'h0)
            $display("FAIL halt_reached got=%0b %0b %h exp=1 0 0", halted, out_valid, instruction_copy); else passed++;
        flush = 1'b1;
        step();
        flush = 1'b0; drive(1'b1, 32'h4, INS_A); #1;
        total++; if (halted !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL halt_sticky got=%0b %0b %0b exp=1 0 0", halted, in_ready, out_valid); else passed++;
        step();
        total++; if (halted !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL halt_no_fetch got=%0b %0b exp=1 0", halted, out_valid); else passed++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_wrong_path_halt();
        test_reset_mid();
        test_halt();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
